// File: rtl/quantizer_pkg.sv
// Shared types, JPEG reference matrices and reciprocal helper for the quantizer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: comp_t (luma/chroma select), state_t (block FSM), QSHIFT (fixed-point
// scale of the reciprocal tables), standard JPEG quantization matrices and
// default_recip(), which gives floor(2^QSHIFT / Qstd) for one table entry.
package quantizer_pkg;

    typedef enum logic {
        COMP_Y = 1'b0,
        COMP_C = 1'b1
    } comp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Reciprocals are stored as round-down of 2^QSHIFT / Qstd.
    localparam int QSHIFT = 12;

    // Row-major, index = row*8 + col.
    localparam int unsigned Q_LUMA [64] = '{
        16,  11,  10,  16,  24,  40,  51,  61,
        12,  12,  14,  19,  26,  58,  60,  55,
        14,  13,  16,  24,  40,  57,  69,  56,
        14,  17,  22,  29,  51,  87,  80,  62,
        18,  22,  37,  56,  68, 109, 103,  77,
        24,  35,  55,  64,  81, 104, 113,  92,
        49,  64,  78,  87, 103, 121, 120, 101,
        72,  92,  95,  98, 112, 100, 103,  99
    };

    localparam int unsigned Q_CHROMA [64] = '{
        17,  18,  24,  47,  99,  99,  99,  99,
        18,  21,  26,  66,  99,  99,  99,  99,
        24,  26,  56,  99,  99,  99,  99,  99,
        47,  66,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99
    };

    // Intended for elaboration-time use only (constant tables).
    function automatic int unsigned default_recip(input comp_t comp, input int row, input int col);
        int unsigned q;
        int unsigned one;
        one = 32'd1 << QSHIFT;
        q   = (comp == COMP_Y) ? Q_LUMA[row*8 + col] : Q_CHROMA[row*8 + col];
        return one / q;
    endfunction

endpackage

// File: rtl/quantizer_multi_lane.sv
// One-element quantizer: signed multiply by reciprocal, round half toward +inf, saturate.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
//
// Ports: i_z (signed coefficient), i_recip (unsigned reciprocal, 2^QSHIFT scale),
//        o_q (signed saturated result). A zero reciprocal yields zero.
// OUT_W must be smaller than DATA_W + RECIP_W + 2 - QSHIFT so the saturation window exists.
module quant_lane
#(
    parameter int DATA_W  = 11,
    parameter int OUT_W   = 11,
    parameter int RECIP_W = 13
) (
    input  logic signed [DATA_W-1:0]  i_z,
    input  logic        [RECIP_W-1:0] i_recip,
    output logic signed [OUT_W-1:0]   o_q
);
    import quantizer_pkg::*;

    localparam int PROD_W = DATA_W + RECIP_W + 1;
    // Shifted product plus one guard bit so the rounding increment cannot wrap.
    localparam int RES_W  = PROD_W - QSHIFT + 1;

    logic signed [PROD_W-1:0] w_z_ext;
    logic signed [PROD_W-1:0] w_r_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [RES_W-1:0]  w_res;
    logic                     w_ovf;
    logic                     w_unused_lsbs;

    assign w_z_ext = {{(PROD_W-DATA_W){i_z[DATA_W-1]}}, i_z};
    assign w_r_ext = {{(PROD_W-RECIP_W){1'b0}}, i_recip};
    assign w_prod  = w_z_ext * w_r_ext;

    // Arithmetic shift by QSHIFT, then add the first discarded bit: half rounds up.
    assign w_res = {w_prod[PROD_W-1], w_prod[PROD_W-1:QSHIFT]} + RES_W'(w_prod[QSHIFT-1]);

    // Fits in OUT_W only if every bit from the OUT_W sign bit upward agrees.
    assign w_ovf = !((&w_res[RES_W-1:OUT_W-1]) || (~|w_res[RES_W-1:OUT_W-1]));

    // Bits below the rounding bit are intentionally discarded.
    assign w_unused_lsbs = ^w_prod[QSHIFT-2:0];

    always_comb begin
        o_q = w_res[OUT_W-1:0];
        if (w_ovf) begin
            o_q = w_res[RES_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/quantizer_multi.sv
// 8x8 JPEG block quantizer, ROWS_PER_CYCLE rows per clock through quant_lane instances.
// Latency: out_enable 8/ROWS_PER_CYCLE + 1 cycles after the cycle enable is presented.
// Backpressure: none; enable is accepted only in IDLE/DONE and silently ignored in RUN.
//
// Ports: clk; rst (sync, active-low); enable/comp_sel/Z (start pulse, table select,
//        signed block); Q (registered block), out_enable (DONE pulse), busy (RUN..DONE).
// Optional QUANT_TABLE_LOAD_EN: adds tbl_we/tbl_comp/tbl_addr/tbl_wdata runtime table
// writes (IDLE/DONE only) and tbl_err, a one-cycle pulse when a write arrives in RUN.
module quantizer_multi
#(
    parameter int DATA_W         = 11,
    parameter int OUT_W          = 11,
    parameter int ROWS_PER_CYCLE = 1,   // 1, 2, 4 or 8
    parameter int RECIP_W        = 13
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     comp_sel,
    input  logic signed [DATA_W-1:0] Z [0:7][0:7],
    output logic signed [OUT_W-1:0]  Q [0:7][0:7],
    output logic                     out_enable,
    output logic                     busy
`ifdef QUANT_TABLE_LOAD_EN
    ,
    input  logic                     tbl_we,
    input  logic                     tbl_comp,
    input  logic [5:0]               tbl_addr,
    input  logic [RECIP_W-1:0]       tbl_wdata,
    output logic                     tbl_err
`endif
);
    import quantizer_pkg::*;

    localparam int         RPC      = ROWS_PER_CYCLE;
    // cnt is 3 bits; with RPC = 8 the step wraps to 0, which is harmless (single group).
    localparam logic [2:0] CNT_STEP = 3'(RPC);
    localparam logic [2:0] LAST_CNT = 3'(8 - RPC);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [2:0]               r_cnt;
    comp_t                    r_comp;
    logic signed [DATA_W-1:0] r_z [0:7][0:7];
    logic signed [OUT_W-1:0]  r_q [0:7][0:7];
    logic                     w_accept;

    logic        [RECIP_W-1:0] w_def    [0:1][0:63];
    logic signed [OUT_W-1:0]   w_lane_q [0:RPC-1][0:7];

    // Default reciprocal tables as elaboration-time constants.
    for (genvar c = 0; c < 2; c++) begin : g_def_c
        for (genvar a = 0; a < 64; a++) begin : g_def_a
            localparam int unsigned RV = default_recip((c == 0) ? COMP_Y : COMP_C, a / 8, a % 8);
            assign w_def[c][a] = RECIP_W'(RV);
        end
    end

`ifdef QUANT_TABLE_LOAD_EN
    logic [RECIP_W-1:0] r_tbl [0:1][0:63];
    logic               r_tbl_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tbl_err <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                for (int a = 0; a < 64; a++) begin
                    r_tbl[c][a] <= w_def[c][a];
                end
            end
        end else begin
            r_tbl_err <= tbl_we && (r_state == ST_RUN);
            // The table feeds the lanes during RUN, so writes are only taken outside it.
            if (tbl_we && (r_state != ST_RUN)) begin
                r_tbl[tbl_comp][tbl_addr] <= tbl_wdata;
            end
        end
    end

    assign tbl_err = r_tbl_err;
`endif

    assign w_accept = enable && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (enable) w_state_nxt = ST_RUN;
            ST_RUN:  if (r_cnt == LAST_CNT) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = enable ? ST_RUN : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        out_enable = (r_state == ST_DONE);
        busy       = (r_state == ST_RUN) || (r_state == ST_DONE);
    end

    // Block capture and row counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_comp <= COMP_Y;
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 8; j++) begin
                    r_z[i][j] <= '0;
                end
            end
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_comp <= comp_sel ? COMP_C : COMP_Y;
            r_z    <= Z;
        end else if (r_state == ST_RUN) begin
            r_cnt <= r_cnt + CNT_STEP;
        end
    end

    // Lane g handles row r_cnt+g of the current group.
    for (genvar g = 0; g < RPC; g++) begin : g_lane
        logic [2:0] w_row;
        assign w_row = r_cnt + 3'(g);
        for (genvar j = 0; j < 8; j++) begin : g_col
            logic [RECIP_W-1:0] w_recip;
`ifdef QUANT_TABLE_LOAD_EN
            assign w_recip = r_tbl[r_comp][{w_row, 3'(j)}];
`else
            assign w_recip = w_def[r_comp][{w_row, 3'(j)}];
`endif
            quant_lane #(
                .DATA_W  (DATA_W),
                .OUT_W   (OUT_W),
                .RECIP_W (RECIP_W)
            ) u_lane (
                .i_z     (r_z[w_row][j]),
                .i_recip (w_recip),
                .o_q     (w_lane_q[g][j])
            );
        end
    end

    // Row r belongs to the group starting at r - r%RPC and comes from lane r%RPC;
    // unprocessed rows keep the previous block's values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    r_q[r][c] <= '0;
                end
            end
        end else if (r_state == ST_RUN) begin
            for (int r = 0; r < 8; r++) begin
                if (r_cnt == 3'(r - (r % RPC))) begin
                    r_q[r] <= w_lane_q[r % RPC];
                end
            end
        end
    end

    assign Q = r_q;

endmodule

// File: tb/tb_quantizer_multi.sv
module tb_quantizer_multi;

    logic                clk = 1'b0;
    logic                rst;
    logic                enable;
    logic                comp_sel;
    logic signed [10:0]  Z  [0:7][0:7];
    logic signed [10:0]  q0 [0:7][0:7];
    logic signed [10:0]  q8 [0:7][0:7];
    logic signed [5:0]   q6 [0:7][0:7];
    logic                oe0, oe8, oe6;
    logic                busy0, busy8, busy6;
    int                  cyc = 0;
    int                  checks = 0;
    int                  errors = 0;

`ifdef QUANT_TABLE_LOAD_EN
    logic                tbl_we;
    logic                tbl_comp;
    logic [5:0]          tbl_addr;
    logic [12:0]         tbl_wdata;
    logic                terr0, terr8, terr6;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    quantizer_multi #(.ROWS_PER_CYCLE(1)) u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .comp_sel(comp_sel), .Z(Z), .Q(q0),
        .out_enable(oe0), .busy(busy0)
`ifdef QUANT_TABLE_LOAD_EN
        , .tbl_we(tbl_we), .tbl_comp(tbl_comp), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata), .tbl_err(terr0)
`endif
    );

    quantizer_multi #(.ROWS_PER_CYCLE(8)) u_dut8 (
        .clk(clk), .rst(rst), .enable(enable), .comp_sel(comp_sel), .Z(Z), .Q(q8),
        .out_enable(oe8), .busy(busy8)
`ifdef QUANT_TABLE_LOAD_EN
        , .tbl_we(tbl_we), .tbl_comp(tbl_comp), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata), .tbl_err(terr8)
`endif
    );

    quantizer_multi #(.OUT_W(6)) u_dut6 (
        .clk(clk), .rst(rst), .enable(enable), .comp_sel(comp_sel), .Z(Z), .Q(q6),
        .out_enable(oe6), .busy(busy6)
`ifdef QUANT_TABLE_LOAD_EN
        , .tbl_we(tbl_we), .tbl_comp(tbl_comp), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata), .tbl_err(terr6)
`endif
    );

    typedef struct {
        logic ramp;    // 1: Z[i][j] = i*8+j, else all zc
        int   zc;
        logic comp;
        int   r;
        int   c;
        int   exp_q;   // OUT_W = 11
        int   exp_q6;  // OUT_W = 6
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    task automatic drive_block(input logic ramp, input int zc, input logic comp);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                Z[i][j] = ramp ? 11'(i*8 + j) : 11'(zc);
        comp_sel = comp;
        enable   = 1'b1;
    endtask

    // Returns absolute cycle numbers of out_enable on dut0 and dut8 (-1 on timeout).
    task automatic wait_out0(output int te0, output int te8);
        te0 = -1;
        te8 = -1;
        for (int n = 0; n < 30 && te0 < 0; n++) begin
            step();
            if (oe8 && te8 < 0) te8 = cyc;
            if (oe0) te0 = cyc;
        end
    endtask

    function automatic int nonzero0();
        int n = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (q0[i][j] != 0) n++;
        return n;
    endfunction

    function automatic int nonzero8();
        int n = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (q8[i][j] != 0) n++;
        return n;
    endfunction

    initial begin
        int t0, te0, te8, seen;

        vecs[0]  = '{1'b0,  1023, 1'b0, 0, 0,  64,  31};
        vecs[1]  = '{1'b0,  1023, 1'b1, 0, 0,  60,  31};
        vecs[2]  = '{1'b0, -1024, 1'b0, 0, 0, -64, -32};
        vecs[3]  = '{1'b1,     0, 1'b0, 0, 0,   0,   0};
        vecs[4]  = '{1'b1,     0, 1'b0, 7, 7,   1,   1};
        vecs[5]  = '{1'b1,     0, 1'b0, 1, 0,   1,   1};
        vecs[6]  = '{1'b0,   500, 1'b0, 0, 0,  31,  31};
        vecs[7]  = '{1'b0,  -500, 1'b0, 0, 0, -31, -31};
        vecs[8]  = '{1'b0,     8, 1'b0, 0, 0,   1,   1};
        vecs[9]  = '{1'b0,    -8, 1'b0, 0, 0,   0,   0};
        vecs[10] = '{1'b0,  1023, 1'b1, 7, 7,  10,  10};
        vecs[11] = '{1'b0,  1023, 1'b0, 4, 5,   9,   9};
        vecs[12] = '{1'b0,  1023, 1'b0, 3, 4,  20,  20};
        vecs[13] = '{1'b0,  1023, 1'b0, 6, 0,  21,  21};
        vecs[14] = '{1'b0,  1023, 1'b0, 1, 1,  85,  31};
        vecs[15] = '{1'b0, -1024, 1'b1, 0, 0, -60, -32};

        rst      = 1'b0;
        enable   = 1'b0;
        comp_sel = 1'b0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                Z[i][j] = '0;
`ifdef QUANT_TABLE_LOAD_EN
        tbl_we    = 1'b0;
        tbl_comp  = 1'b0;
        tbl_addr  = '0;
        tbl_wdata = '0;
`endif
        step(); step(); step();

        // Reset state
        check("reset out_enable", int'(oe0), 0);
        check("reset busy", int'(busy0), 0);
        check("reset Q nonzero count", nonzero0(), 0);
        rst = 1'b1;
        step();

        // Table-driven vectors; each block after the first starts in the DONE cycle.
        for (int k = 0; k < NV; k++) begin
            drive_block(vecs[k].ramp, vecs[k].zc, vecs[k].comp);
            t0 = cyc;
            wait_out0(te0, te8);
            check($sformatf("vec%0d latency rpc1", k), (te0 < 0) ? -1 : te0 - t0, 9);
            check($sformatf("vec%0d latency rpc8", k), (te8 < 0) ? -1 : te8 - t0, 2);
            check($sformatf("vec%0d Q[%0d][%0d]", k, vecs[k].r, vecs[k].c),
                  int'(q0[vecs[k].r][vecs[k].c]), vecs[k].exp_q);
            check($sformatf("vec%0d rpc8 Q[%0d][%0d]", k, vecs[k].r, vecs[k].c),
                  int'(q8[vecs[k].r][vecs[k].c]), vecs[k].exp_q);
            check($sformatf("vec%0d outw6 Q[%0d][%0d]", k, vecs[k].r, vecs[k].c),
                  int'(q6[vecs[k].r][vecs[k].c]), vecs[k].exp_q6);
        end

        // Reference block: all 1023 luma, Q[7][0] = 14.
        drive_block(1'b0, 1023, 1'b0);
        wait_out0(te0, te8);
        check("busy in DONE", int'(busy0), 1);

        // Partial write: after one RUN cycle only row 0 holds the new block.
        drive_block(1'b0, -1024, 1'b0);
        step();
        check("b2b busy after accept", int'(busy0), 1);
        check("b2b no out_enable after accept", int'(oe0), 0);
        step();
        check("partial new row0", int'(q0[0][0]), -64);
        check("partial old row7", int'(q0[7][0]), 14);
        wait_out0(te0, te8);
        check("partial final row7", int'(q0[7][0]), -14);

        // Enable re-pulsed in RUN with a different block must be ignored.
        drive_block(1'b0, 1023, 1'b0);
        t0 = cyc;
        step(); step(); step();
        drive_block(1'b0, -1024, 1'b1);
        wait_out0(te0, te8);
        check("midrun latency", (te0 < 0) ? -1 : te0 - t0, 9);
        check("midrun Q[0][0]", int'(q0[0][0]), 64);
        check("midrun Q[7][0]", int'(q0[7][0]), 14);

        // Let the block end and the FSM return to IDLE.
        step();
        check("idle after DONE busy", int'(busy0), 0);

        // Reset during RUN cycle 4 aborts the block.
        drive_block(1'b0, 1023, 1'b0);
        step(); step(); step(); step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("abort out_enable", int'(oe0), 0);
        check("abort busy", int'(busy0), 0);
        check("abort Q nonzero count", nonzero0(), 0);
        check("abort rpc8 Q nonzero count", nonzero8(), 0);
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            step();
            if (oe0) seen++;
        end
        check("abort no later out_enable", seen, 0);

`ifdef QUANT_TABLE_LOAD_EN
        // Table write in IDLE: luma[0][0] = 4096 makes Q = Z.
        tbl_we    = 1'b1;
        tbl_comp  = 1'b0;
        tbl_addr  = 6'd0;
        tbl_wdata = 13'd4096;
        step();
        tbl_we = 1'b0;
        check("tbl idle no err", int'(terr0), 0);
        drive_block(1'b0, 5, 1'b0);
        wait_out0(te0, te8);
        check("tbl loaded Q[0][0]", int'(q0[0][0]), 5);

        // Table write during RUN is dropped and flagged for one cycle.
        drive_block(1'b0, 5, 1'b0);
        step();
        tbl_we    = 1'b1;
        tbl_wdata = 13'd0;
        step();
        tbl_we = 1'b0;
        check("tbl run err pulse", int'(terr0), 1);
        step();
        check("tbl run err one cycle", int'(terr0), 0);
        wait_out0(te0, te8);
        check("tbl unchanged Q[0][0]", int'(q0[0][0]), 5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/quantizer_multi.md
QUANTIZER_MULTI -- requirements
Module: quantizer_multi

Interface
REQ-001 SHALL have parameter DATA_W, default 11, signed input coefficient width.
REQ-002 SHALL have parameter OUT_W, default 11, signed quantized output width.
REQ-003 SHALL have parameter ROWS_PER_CYCLE, default 1, rows quantized per cycle; legal values are 1, 2, 4 and 8.
REQ-004 SHALL have parameter RECIP_W, default 13, unsigned reciprocal table entry width.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1, reset; synchronous and active-low.
REQ-007 SHALL have port enable, input, 1, start pulse; latches Z and comp_sel.
REQ-008 SHALL have port comp_sel, input, 1, table select: 0 = luma, 1 = chroma.
REQ-009 SHALL have port Z, input, [DATA_W] x 8 x 8, signed DCT block.
REQ-010 SHALL have port Q, output, [OUT_W] x 8 x 8, signed quantized block, registered.
REQ-011 SHALL have port out_enable, output, 1, one-cycle pulse when Q is complete.
REQ-012 SHALL have port busy, output, 1, high from the accepted enable until the out_enable cycle, inclusive.

Function
REQ-013 SHALL run the FSM IDLE -> RUN -> DONE -> IDLE; an accepted enable moves to RUN with row counter 0.
REQ-014 SHALL, in RUN, process rows [cnt .. cnt+ROWS_PER_CYCLE-1] each cycle, advance cnt by ROWS_PER_CYCLE, and move to DONE after the row-7 group.
REQ-015 SHALL assert out_enable for exactly the single DONE cycle; latency from the enable edge to out_enable is 8/ROWS_PER_CYCLE + 1 cycles.
REQ-016 SHALL accept enable only in IDLE or DONE; enable in DONE starts the next block back-to-back with no idle cycle.
REQ-017 SHALL ignore enable while in RUN; the latched block and comp_sel stay unchanged.
REQ-018 SHALL compute per element prod = Zlatched * recip[comp][i][j], signed, width DATA_W+RECIP_W+1.
REQ-019 SHALL compute result = (prod >>> 12) + prod[11], i.e. round half toward +inf.
REQ-020 SHALL saturate result to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-021 SHALL write each Q row only in its processing cycle; rows not yet processed keep their previous-block values.
REQ-022 SHALL produce Q = 0 for an element whose recip entry is 0.
REQ-023 SHALL use default recip = floor(4096 / Qstd[i][j]) from the standard JPEG luma and chroma matrices.

Reset
REQ-024 SHALL, with rst = 0 at a clock edge, set FSM = IDLE, cnt = 0, Q all 0, out_enable = 0, busy = 0, and tables to their defaults.
REQ-025 SHALL abort an in-flight block on reset mid-RUN: no out_enable, and Q cleared to 0.

Configuration
REQ-026 SHALL, with QUANT_TABLE_LOAD_EN defined, add these ports: tbl_we (1), tbl_comp (1), tbl_addr (6, row*8+col) and tbl_wdata (RECIP_W).
REQ-027 SHALL, with QUANT_TABLE_LOAD_EN defined, write a tbl_we cycle in IDLE or DONE into the selected table, effective for blocks accepted from the next cycle on.
REQ-028 SHALL, with QUANT_TABLE_LOAD_EN defined, drop a tbl_we in RUN (no write) and pulse the added output tbl_err for 1 cycle.
REQ-029 SHALL, without QUANT_TABLE_LOAD_EN, hold tables constant at the defaults and omit tbl_* ports and table storage registers.

Structure
REQ-030 SHALL place in shared package quantizer_pkg: comp_t enum (COMP_Y, COMP_C), the standard luma and chroma Q matrices, QSHIFT = 12, and the default reciprocal function.
REQ-031 SHALL implement one element's multiply, round and saturate in a combinational sub-module quant_lane, instantiated 8*ROWS_PER_CYCLE times.

Verification
REQ-032 SHALL cover: all-1023 block, comp_sel = 0 -> Q[0][0] = 64 (recip 256); out_enable exactly 9 cycles after enable for ROWS_PER_CYCLE = 1 and 2 cycles for ROWS_PER_CYCLE = 8.
REQ-033 SHALL cover: all-1023 block, comp_sel = 1 -> Q[0][0] = 60 (recip 240); a -1024 block, luma -> Q[0][0] = -64; a ramp (i*8+j) block -> Q[0][0] = 0.
REQ-034 SHALL cover: OUT_W = 6, all-1023 block, luma -> Q[0][0] saturates to 31; an all-(-1024) block -> Q[0][0] = -32.
REQ-035 SHALL cover: enable re-pulsed mid-RUN with different Z -> it is ignored and the output matches the first block; enable in the DONE cycle -> second out_enable exactly 9 cycles later.
REQ-036 SHALL cover: rst low in RUN cycle 4 -> no out_enable, Q all 0, busy = 0 the next cycle.
REQ-037 SHALL cover, with QUANT_TABLE_LOAD_EN defined: write luma addr 0 = 4096, then Z[0][0] = 5 -> Q[0][0] = 5; a tbl_we during RUN -> tbl_err pulses and the table is unchanged.
